ping_echo_sequencer: RTL and testbench

// Parametrised pulse-echo controller for the ultrasonic mic array: generates an N-cycle

---
 rtl/ping_echo_sequencer.sv | 150 +++++++++++++++
 tb/tb_ping_echo_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ping_echo_sequencer.sv
// Pulse-echo controller: differential carrier burst with dead time, programmable wait, then a
// gated multi-channel record window. Single-shot or continuous re-arm, abort, frame counter.
module ping_echo_sequencer #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int CARRIER_HZ = 40_000,
    parameter int N_CH       = 16,
    parameter int CNT_W      = 24,
    parameter int DEADTIME   = 4
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic             continuous,
    input  logic             abort,
    input  logic [7:0]       burst_cycles,
    input  logic [CNT_W-1:0] rec_delay,
    input  logic [CNT_W-1:0] rec_len,
    input  logic [N_CH-1:0]  ch_enable,
    output logic             tx_p,
    output logic             tx_n,
    output logic [N_CH-1:0]  mic_on,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frame_count,
    output logic [1:0]       state_out
);
    localparam int HALF_DIV = CLK_HZ / (2 * CARRIER_HZ);
    localparam int HW       = $clog2(HALF_DIV + 1);
    localparam logic [HW-1:0]    HMAX   = HW'(HALF_DIV - 1);
    localparam logic [HW-1:0]    DT     = HW'(DEADTIME);
    localparam logic [CNT_W-1:0] PERIOD = CNT_W'(2 * HALF_DIV);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_TX = 2'd1, S_WAIT = 2'd2, S_REC = 2'd3} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_rem;
    logic [HW-1:0]    r_cnt;
    logic             r_phase;
    logic [CNT_W-1:0] r_delay;
    logic [CNT_W-1:0] r_len;
    logic [N_CH-1:0]  r_mask;
    logic             r_tx_p, r_tx_n, r_busy, r_frame_done;
    logic [N_CH-1:0]  r_mic_on;
    logic [15:0]      r_frame_count;

    logic             w_rem_last, w_wrap, w_phase_nxt, w_enter_tx, w_frame_end;
    logic [HW-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0] w_tx_len;

    // r_rem holds the remaining cycles of the current state minus one
    assign w_rem_last  = (r_rem == '0);
    assign w_wrap      = (r_cnt == HMAX);
    assign w_cnt_nxt   = w_wrap ? '0 : r_cnt + HW'(1);
    assign w_phase_nxt = w_wrap ? ~r_phase : r_phase;
    assign w_tx_len    = (burst_cycles == 8'd0) ? '0
                       : PERIOD * CNT_W'(burst_cycles) - CNT_W'(1);
    assign w_frame_end = (r_state == S_REC) && w_rem_last;
    assign w_enter_tx  = ((r_state == S_IDLE) && start) || (w_frame_end && continuous);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_rem         <= '0;
            r_cnt         <= '0;
            r_phase       <= 1'b0;
            r_delay       <= '0;
            r_len         <= '0;
            r_mask        <= '0;
            r_tx_p        <= 1'b0;
            r_tx_n        <= 1'b0;
            r_mic_on      <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (abort) begin
                r_state  <= S_IDLE;
                r_busy   <= 1'b0;
                r_rem    <= '0;
                r_tx_p   <= 1'b0;
                r_tx_n   <= 1'b0;
                r_mic_on <= '0;
            end else if (w_enter_tx) begin
                if (w_frame_end) begin
                    r_frame_done  <= 1'b1;
                    r_frame_count <= r_frame_count + 16'd1;
                end
                r_state  <= S_TX;
                r_busy   <= 1'b1;
                r_delay  <= rec_delay;
                r_len    <= rec_len;
                r_mask   <= ch_enable;
                r_rem    <= w_tx_len;
                r_cnt    <= '0;
                r_phase  <= 1'b1;
                r_tx_p   <= (burst_cycles != 8'd0) && (DT == '0);
                r_tx_n   <= 1'b0;
                r_mic_on <= '0;
            end else begin
                case (r_state)
                    S_TX: begin
                        if (w_rem_last) begin
                            r_state <= S_WAIT;
                            r_rem   <= (r_delay == '0) ? '0 : r_delay - CNT_W'(1);
                            r_tx_p  <= 1'b0;
                            r_tx_n  <= 1'b0;
                        end else begin
                            r_rem   <= r_rem - CNT_W'(1);
                            r_cnt   <= w_cnt_nxt;
                            r_phase <= w_phase_nxt;
                            r_tx_p  <= w_phase_nxt && (w_cnt_nxt >= DT);
                            r_tx_n  <= !w_phase_nxt && (w_cnt_nxt >= DT);
                        end
                    end
                    S_WAIT: begin
                        if (w_rem_last) begin
                            r_state  <= S_REC;
                            r_rem    <= (r_len == '0) ? '0 : r_len - CNT_W'(1);
                            r_mic_on <= (r_len == '0) ? '0 : r_mask;
                        end else begin
                            r_rem <= r_rem - CNT_W'(1);
                        end
                    end
                    S_REC: begin
                        // continuous re-arm is taken by the TX-entry branch above
                        if (w_rem_last) begin
                            r_state       <= S_IDLE;
                            r_busy        <= 1'b0;
                            r_mic_on      <= '0;
                            r_frame_done  <= 1'b1;
                            r_frame_count <= r_frame_count + 16'd1;
                        end else begin
                            r_rem <= r_rem - CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tx_p        = r_tx_p;
    assign tx_n        = r_tx_n;
    assign mic_on      = r_mic_on;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;
    assign state_out   = r_state;
endmodule

// File: tb/tb_ping_echo_sequencer.sv
// Bench for ping_echo_sequencer: directed corner sequences, a vector table and randomized
// traffic, all checked per cycle against a timeline model of the ping frame.
module tb_ping_echo_sequencer;
    localparam int CLK_HZ = 800, CARRIER_HZ = 100, N_CH = 4, CNT_W = 24, DEADTIME = 1;
    localparam int HD = CLK_HZ / (2 * CARRIER_HZ);

    logic             clk = 1'b0;
    logic             reset, start, continuous, abort;
    logic [7:0]       burst;
    logic [CNT_W-1:0] dly, len;
    logic [N_CH-1:0]  mask;
    logic             tx_p, tx_n, busy, frame_done;
    logic [N_CH-1:0]  mic_on;
    logic [15:0]      frame_count;
    logic [1:0]       state_out;

    ping_echo_sequencer #(
        .CLK_HZ(CLK_HZ), .CARRIER_HZ(CARRIER_HZ), .N_CH(N_CH), .CNT_W(CNT_W), .DEADTIME(DEADTIME)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .continuous(continuous), .abort(abort),
        .burst_cycles(burst), .rec_delay(dly), .rec_len(len), .ch_enable(mask),
        .tx_p(tx_p), .tx_n(tx_n), .mic_on(mic_on), .busy(busy), .frame_done(frame_done),
        .frame_count(frame_count), .state_out(state_out)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Model: phase of the frame (0 idle,1 burst,2 wait,3 record) and cycles elapsed in it
    int          m_st, m_t, m_burst, m_delay, m_len;
    logic [3:0]  m_mask;
    logic        m_fd;
    logic [15:0] m_cnt;

    function automatic int dur_of(int st);
        case (st)
            1:       return (m_burst == 0) ? 1 : 2 * HD * m_burst;
            2:       return (m_delay == 0) ? 1 : m_delay;
            3:       return (m_len == 0) ? 1 : m_len;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_st = 0; m_t = 0; m_fd = 1'b0; m_cnt = '0;
        m_burst = 0; m_delay = 0; m_len = 0; m_mask = '0;
    endtask

    task automatic enter_tx();
        m_burst = int'(burst); m_delay = int'(dly); m_len = int'(len); m_mask = mask;
        m_st = 1; m_t = 0;
    endtask

    task automatic model_step();
        if (reset) begin
            model_reset();
            return;
        end
        m_fd = 1'b0;
        if (abort) begin
            m_st = 0; m_t = 0;
        end else if (m_st == 0) begin
            if (start) enter_tx();
        end else if (m_t + 1 < dur_of(m_st)) begin
            m_t++;
        end else begin
            case (m_st)
                1: begin m_st = 2; m_t = 0; end
                2: begin m_st = 3; m_t = 0; end
                default: begin
                    m_fd = 1'b1;
                    m_cnt++;
                    if (continuous) enter_tx();
                    else begin m_st = 0; m_t = 0; end
                end
            endcase
        end
    endtask

    function automatic logic [25:0] model_out();
        logic on, ep, en;
        logic [3:0] mic;
        on  = (m_st == 1) && (m_burst != 0) && ((m_t % HD) >= DEADTIME);
        ep  = on && ((m_t % (2 * HD)) < HD);
        en  = on && ((m_t % (2 * HD)) >= HD);
        mic = (m_st == 3 && m_len != 0) ? m_mask : 4'h0;
        return {ep, en, mic, (m_st != 0), m_fd, m_cnt, 2'(m_st)};
    endfunction

    task automatic check(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare(string name);
        logic [25:0] act, exp;
        act = {tx_p, tx_n, mic_on, busy, frame_done, frame_count, state_out};
        exp = model_out();
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 25)
                $display("FAIL %s: got {txp,txn,mic,busy,fd,cnt,st}=%h expected %h at %0t",
                         name, act, exp, $time);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare("cycle");
    endtask

    always @(negedge clk) begin
        checks++;
        if (tx_p && tx_n) begin
            errors++;
            $display("FAIL tx_overlap: got tx_p=1 tx_n=1 expected never both at %0t", $time);
        end
    end

    typedef struct {
        int         b;
        int         d;
        int         l;
        logic [3:0] m;
        int         cyc;
    } vec_t;
    vec_t tbl[5];

    task automatic cfg(int b, int d, int l, logic [3:0] m);
        burst = 8'(b); dly = CNT_W'(d); len = CNT_W'(l); mask = m;
    endtask

    initial begin
        logic [15:0] vp, vn;
        int bc, guard, stamp[3], nfd, cyc;
        logic [15:0] cnt_before;

        tbl[0] = '{b: 2, d: 3, l: 5, m: 4'b1011, cyc: 24};
        tbl[1] = '{b: 0, d: 0, l: 0, m: 4'b1111, cyc: 3};
        tbl[2] = '{b: 1, d: 0, l: 2, m: 4'b0101, cyc: 11};
        tbl[3] = '{b: 3, d: 2, l: 1, m: 4'b1111, cyc: 27};
        tbl[4] = '{b: 0, d: 5, l: 0, m: 4'b0001, cyc: 7};

        reset = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0;
        cfg(0, 0, 0, 4'h0);
        model_reset();
        #2;
        compare("reset_state");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tick(); tick();

        // single-shot frame with known carrier pattern
        cfg(2, 3, 5, 4'b1011);
        start = 1'b1; tick(); start = 1'b0;
        vp = '0; vn = '0;
        for (int i = 0; i < 16; i++) begin
            vp = {vp[14:0], tx_p};
            vn = {vn[14:0], tx_n};
            tick();
        end
        check("tx_p_pattern", int'(vp), int'(16'b0111_0000_0111_0000));
        check("tx_n_pattern", int'(vn), int'(16'b0000_0111_0000_0111));
        check("wait_state", int'(state_out), 2);
        repeat (3) tick();
        check("rec_mask", int'(mic_on), int'(4'b1011));
        repeat (5) tick();
        check("frame_done_pulse", int'(frame_done), 1);
        check("frame_count_1", int'(frame_count), 1);
        check("idle_after", int'(state_out), 0);
        tick();
        check("frame_done_single", int'(frame_done), 0);

        // asynchronous reset in the middle of the record window
        start = 1'b1; tick(); start = 1'b0;
        repeat (21) tick();
        check("in_rec", int'(state_out), 3);
        reset = 1'b1;
        #1;
        check("async_rst_state", int'(state_out), 0);
        check("async_rst_mic", int'(mic_on), 0);
        check("async_rst_count", int'(frame_count), 0);
        check("async_rst_busy", int'(busy), 0);
        tick();
        reset = 1'b0;
        tick();

        // vector table of single-shot frames; config scrambled while busy must not matter
        foreach (tbl[k]) begin
            cfg(tbl[k].b, tbl[k].d, tbl[k].l, tbl[k].m);
            start = 1'b1; tick(); start = 1'b0;
            bc = 0; guard = 0;
            while (busy && guard < 200) begin
                bc++; guard++;
                cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), 4'($urandom));
                start = 1'($urandom_range(0, 1));
                tick();
            end
            start = 1'b0;
            check("table_frame_len", bc, tbl[k].cyc);
            check("table_frame_done", int'(frame_done), 1);
            tick();
        end

        // continuous: back-to-back frames, new mask only at the next burst
        cfg(2, 3, 5, 4'b1011);
        continuous = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        mask = 4'b0100;
        nfd = 0; cyc = 0;
        while (nfd < 3 && cyc < 200) begin
            tick(); cyc++;
            if (frame_done) begin stamp[nfd] = cyc; nfd++; end
        end
        check("cont_frames", nfd, 3);
        check("cont_period_1", stamp[1] - stamp[0], 24);
        check("cont_period_2", stamp[2] - stamp[1], 24);
        check("cont_rearm", int'(state_out), 1);
        continuous = 1'b0;
        guard = 0;
        while (busy && guard < 100) begin tick(); guard++; end
        check("cont_stop", int'(busy), 0);
        tick();

        // abort during burst, then abort (with start) during record
        cnt_before = m_cnt;
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_tx_state", int'(state_out), 0);
        check("abort_tx_out", int'({tx_p, tx_n}), 0);
        start = 1'b1; tick(); start = 1'b0;
        repeat (21) tick();
        abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
        check("abort_rec_state", int'(state_out), 0);
        check("abort_rec_mic", int'(mic_on), 0);
        tick();
        check("abort_no_done", int'(frame_done), 0);
        check("abort_count", int'(frame_count), int'(cnt_before));

        // frame counter wrap
        force dut.r_frame_count = 16'hFFFF;
        #1;
        release dut.r_frame_count;
        m_cnt = 16'hFFFF;
        check("count_preset", int'(frame_count), 65535);
        cfg(0, 0, 0, 4'hF);
        start = 1'b1; tick(); start = 1'b0;
        guard = 0;
        while (busy && guard < 20) begin tick(); guard++; end
        check("count_wrap", int'(frame_count), 0);
        check("wrap_done", int'(frame_done), 1);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) continuous = ~continuous;
            cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 6)), 4'($urandom));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
